// File: rtl/sm_run_ctrl_if.sv
// Command and register-dump channels of the run controller.
// The master side issues commands and consumes dump beats; the slave side is the controller.
interface sm_run_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                cmd_valid;
  logic [2:0]          cmd_op;
  logic [PC_WIDTH-1:0] cmd_arg;
  logic                cmd_ready;
  logic                cmd_err;
  logic                dump_valid;
  logic                dump_ready;
  logic [4:0]          dump_addr;
  logic [31:0]         dump_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, cmd_err, dump_valid, dump_addr, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, cmd_err, dump_valid, dump_addr, dump_data
  );
endinterface

// File: rtl/sm_run_ctrl.sv
// Debug run controller: gates the CPU clock enable, single-steps, halts on breakpoint or
// cycle limit, and streams the register file out. Breakpoints exist only with SM_RUN_CTRL_BP_EN.
module sm_run_ctrl #(
  parameter int CYCLE_LIMIT = 200,
  parameter int PC_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  sm_run_ctrl_if.slave        bus,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpu_en,
  output logic [4:0]          reg_addr,
  input  logic [31:0]         reg_data,
  output logic                halted,
  output logic                bp_hit,
  output logic                limit_hit,
  output logic [31:0]         cycle_cnt,
  output logic [2:0]          state_dbg
);
  // Handshakes: a command or dump beat transfers on a rising edge where valid & ready are
  // both high; valid and its payload stay stable until that edge.
  typedef enum logic [2:0] {
    S_HALTED    = 3'd0,
    S_RUN       = 3'd1,
    S_STEP      = 3'd2,
    S_DUMP_ADDR = 3'd3,
    S_DUMP_OUT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_RUN    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_DUMP   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;

  localparam logic [31:0] LIMIT    = 32'(CYCLE_LIMIT);
  localparam bit          LIMIT_ON = (CYCLE_LIMIT != 0);

  state_t      state;
  logic        accept;
  logic        halt_req;
  logic        bp_match;
  logic        limit_reach;
  logic        cmd_noop;
  logic [31:0] cycle_nxt;

  assign bus.cmd_ready = (state == S_HALTED) || (state == S_RUN);
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign halt_req      = accept & (bus.cmd_op == OP_HALT);
  assign halted        = (state == S_HALTED);
  assign state_dbg     = state;

`ifdef SM_RUN_CTRL_BP_EN
  localparam bit BP_ON = 1'b1;
  logic                bp_valid;
  logic [PC_WIDTH-1:0] bp_addr;

  // Match is evaluated before the instruction at bp_addr executes, so it suppresses cpu_en.
  assign bp_match = (state == S_RUN) & bp_valid & (pc == bp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_valid <= 1'b0;
      bp_addr  <= '0;
    end else if (accept && bus.cmd_op == OP_SET_BP) begin
      bp_valid <= 1'b1;
      bp_addr  <= bus.cmd_arg;
    end else if (accept && bus.cmd_op == OP_CLR_BP) begin
      bp_valid <= 1'b0;
    end
  end
`else
  localparam bit BP_ON = 1'b0;
  logic unused_bp;
  assign unused_bp = ^{pc, bus.cmd_arg};
  assign bp_match  = 1'b0;
`endif

  always_comb begin
    cpu_en = 1'b0;
    if (state == S_STEP)
      cpu_en = 1'b1;
    else if (state == S_RUN && !bp_match && !halt_req)
      cpu_en = 1'b1;
  end

  assign cycle_nxt   = cycle_cnt + 32'd1;
  // cpu_en is already low on a breakpoint match, so the breakpoint always wins over the limit.
  assign limit_reach = LIMIT_ON && cpu_en && (cycle_nxt == LIMIT);

  always_comb begin
    cmd_noop = 1'b0;
    if (accept) begin
      case (bus.cmd_op)
        OP_RUN, OP_STEP, OP_DUMP: cmd_noop = (state == S_RUN);
        OP_HALT:                  cmd_noop = (state == S_HALTED);
        OP_SET_BP, OP_CLR_BP:     cmd_noop = !BP_ON;
        default:                  cmd_noop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_HALTED;
      cycle_cnt     <= 32'd0;
      reg_addr      <= 5'd0;
      bus.dump_valid <= 1'b0;
      bus.dump_addr  <= 5'd0;
      bus.dump_data  <= 32'd0;
      bus.cmd_err    <= 1'b0;
      bp_hit        <= 1'b0;
      limit_hit     <= 1'b0;
    end else begin
      bus.cmd_err <= cmd_noop;
      bp_hit      <= bp_match;
      limit_hit   <= limit_reach;
      if (cpu_en)
        cycle_cnt <= cycle_nxt;

      case (state)
        S_HALTED: begin
          if (accept) begin
            case (bus.cmd_op)
              OP_RUN:  state <= S_RUN;
              OP_STEP: state <= S_STEP;
              OP_DUMP: begin
                state    <= S_DUMP_ADDR;
                reg_addr <= 5'd0;
              end
              default: state <= S_HALTED;
            endcase
          end
        end
        S_RUN: begin
          if (bp_match || halt_req || limit_reach)
            state <= S_HALTED;
        end
        S_STEP: state <= S_HALTED;
        S_DUMP_ADDR: begin
          // reg_addr has been stable for a full cycle, so the async read data has settled.
          bus.dump_valid <= 1'b1;
          bus.dump_addr  <= reg_addr;
          bus.dump_data  <= reg_data;
          state          <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            if (reg_addr == 5'd31) begin
              reg_addr <= 5'd0;
              state    <= S_HALTED;
            end else begin
              reg_addr <= reg_addr + 5'd1;
              state    <= S_DUMP_ADDR;
            end
          end
        end
        default: state <= S_HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: command table, cycle limit, breakpoint (or its absence),
// randomized-backpressure register dump and reset during dump.
module tb_sm_run_ctrl;
  localparam int PC_WIDTH = 32;
  localparam logic [2:0] OP_RUN = 3'd0, OP_HALT = 3'd1, OP_STEP = 3'd2, OP_DUMP = 3'd3,
                         OP_SET_BP = 3'd4, OP_CLR_BP = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd0, ST_RUN = 3'd1, ST_STEP = 3'd2;
`ifdef SM_RUN_CTRL_BP_EN
  localparam logic BP_ON = 1'b1;
`else
  localparam logic BP_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PC_WIDTH-1:0] pc;
  logic                cpu_en;
  logic [4:0]          reg_addr;
  logic [31:0]         reg_data;
  logic                halted, bp_hit, limit_hit;
  logic [31:0]         cycle_cnt;
  logic [2:0]          state_dbg;
  logic [31:0]         regs [32];

  int n_tests = 0;
  int n_fail  = 0;

  sm_run_ctrl_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  sm_run_ctrl #(.CYCLE_LIMIT(200), .PC_WIDTH(PC_WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .cpu_en(cpu_en), .reg_addr(reg_addr),
    .reg_data(reg_data), .halted(halted), .bp_hit(bp_hit), .limit_hit(limit_hit),
    .cycle_cnt(cycle_cnt), .state_dbg(state_dbg)
  );

  // clock / reset and CPU model
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign reg_data = regs[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_arg    = '0;
    bus.dump_ready = 1'b0;
    rst = 1'b1;
    #3;
    check("rst halted",     32'(halted), 32'd1);
    check("rst cpu_en",     32'(cpu_en), 32'd0);
    check("rst cycle_cnt",  cycle_cnt, 32'd0);
    check("rst reg_addr",   32'(reg_addr), 32'd0);
    check("rst dump_valid", 32'(bus.dump_valid), 32'd0);
    check("rst pulses",     32'({bus.cmd_err, bp_hit, limit_hit}), 32'd0);
    check("rst cmd_ready",  32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic       valid;
    logic [2:0] op;
    logic       exp_ready;
    logic       exp_en;
    logic [2:0] exp_state;
    logic       exp_err;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] exp_q [$];

  initial begin
    int en_cnt, lh_cnt, bh_cnt, n_xfer, guard;
    logic any_en, prev_hold;
    logic [4:0]  prev_addr, exp_addr;
    logic [31:0] prev_data, exp_data;

    vecs[0]  = '{1'b1, OP_HALT,   1'b1, 1'b0, ST_HALTED, 1'b1};
    vecs[1]  = '{1'b1, 3'd6,      1'b1, 1'b0, ST_HALTED, 1'b1};
    vecs[2]  = '{1'b1, OP_RUN,    1'b1, 1'b0, ST_RUN,    1'b0};
    vecs[3]  = '{1'b1, OP_RUN,    1'b1, 1'b1, ST_RUN,    1'b1};
    vecs[4]  = '{1'b1, OP_STEP,   1'b1, 1'b1, ST_RUN,    1'b1};
    vecs[5]  = '{1'b1, OP_DUMP,   1'b1, 1'b1, ST_RUN,    1'b1};
    vecs[6]  = '{1'b1, 3'd7,      1'b1, 1'b1, ST_RUN,    1'b1};
    vecs[7]  = '{1'b1, OP_CLR_BP, 1'b1, 1'b1, ST_RUN,    !BP_ON};
    vecs[8]  = '{1'b1, OP_HALT,   1'b1, 1'b0, ST_HALTED, 1'b0};
    vecs[9]  = '{1'b1, OP_STEP,   1'b1, 1'b0, ST_STEP,   1'b0};
    vecs[10] = '{1'b1, OP_RUN,    1'b0, 1'b1, ST_HALTED, 1'b0};
    vecs[11] = '{1'b1, OP_CLR_BP, 1'b1, 1'b0, ST_HALTED, !BP_ON};
    for (int i = 0; i < 32; i++) regs[i] = $urandom();

    // command table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.cmd_valid = vecs[i].valid;
      bus.cmd_op    = vecs[i].op;
      bus.cmd_arg   = '0;
      #1;
      check($sformatf("v%0d cmd_ready", i), 32'(bus.cmd_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d cpu_en", i),    32'(cpu_en),        32'(vecs[i].exp_en));
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check($sformatf("v%0d state", i),   32'(state_dbg),   32'(vecs[i].exp_state));
      check($sformatf("v%0d cmd_err", i), 32'(bus.cmd_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d halted", i),  32'(halted),      32'(vecs[i].exp_state == ST_HALTED));
    end
    check("table cycle_cnt", cycle_cnt, 32'd6);

    // cycle limit
    do_reset();
    send_cmd(OP_RUN, 32'd0);
    en_cnt = 0; lh_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (cpu_en) en_cnt++;
      if (limit_hit) lh_cnt++;
      @(posedge clk); #1;
    end
    check("limit en cycles", 32'(en_cnt), 32'd200);
    check("limit cycle_cnt", cycle_cnt, 32'd200);
    check("limit pulses", 32'(lh_cnt), 32'd1);
    check("limit halted", 32'(halted), 32'd1);
    send_cmd(OP_STEP, 32'd0);
    @(posedge clk); #1;
    check("limit step cnt", cycle_cnt, 32'd201);
    check("limit step no pulse", 32'(limit_hit), 32'd0);
    check("limit step halted", 32'(halted), 32'd1);

    // breakpoint
    do_reset();
    send_cmd(OP_SET_BP, 32'h10);
    check("bp set err", 32'(bus.cmd_err), 32'(!BP_ON));
    send_cmd(OP_RUN, 32'd0);
    bh_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bp_hit) bh_cnt++;
      if (pc == 32'h10) check("bp cpu_en at 0x10", 32'(cpu_en), 32'(!BP_ON));
      @(posedge clk); #1;
    end
`ifdef SM_RUN_CTRL_BP_EN
    check("bp pulses", 32'(bh_cnt), 32'd1);
    check("bp halted", 32'(halted), 32'd1);
    check("bp cycle_cnt", cycle_cnt, 32'd4);
    check("bp pc", pc, 32'h10);
    send_cmd(OP_STEP, 32'd0);
    @(posedge clk); #1;
    check("bp step pc", pc, 32'h14);
    check("bp step cycle_cnt", cycle_cnt, 32'd5);
    check("bp step halted", 32'(halted), 32'd1);
`else
    check("nobp pulses", 32'(bh_cnt), 32'd0);
    check("nobp halted", 32'(halted), 32'd0);
    check("nobp cycle_cnt", cycle_cnt, 32'd20);
    check("nobp pc", pc, 32'd80);
    send_cmd(OP_HALT, 32'd0);
    check("nobp halt", 32'(halted), 32'd1);
`endif

    // register dump with random backpressure; scoreboard
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);
    send_cmd(OP_DUMP, 32'd0);
    n_xfer = 0; guard = 0; any_en = 1'b0; prev_hold = 1'b0;
    prev_addr = '0; prev_data = '0; exp_addr = '0;
    while (n_xfer < 32 && guard < 2000) begin
      bus.dump_ready = 1'($urandom_range(0, 1));
      #1;
      if (cpu_en) any_en = 1'b1;
      if (prev_hold) begin
        check("dump hold valid", 32'(bus.dump_valid), 32'd1);
        check("dump hold data", bus.dump_data, prev_data);
        check("dump hold addr", 32'(bus.dump_addr), 32'(prev_addr));
      end
      if (bus.dump_valid && bus.dump_ready) begin
        exp_data = exp_q.pop_front();
        check($sformatf("dump addr %0d", n_xfer), 32'(bus.dump_addr), 32'(exp_addr));
        check($sformatf("dump data %0d", n_xfer), bus.dump_data, exp_data);
        exp_addr = exp_addr + 5'd1;
        n_xfer++;
      end
      prev_hold = bus.dump_valid && !bus.dump_ready;
      prev_addr = bus.dump_addr;
      prev_data = bus.dump_data;
      @(posedge clk); #1;
      guard++;
    end
    bus.dump_ready = 1'b0;
    check("dump transfers", 32'(n_xfer), 32'd32);
    check("dump cpu_en low", 32'(any_en), 32'd0);
    check("dump halted", 32'(halted), 32'd1);
    check("dump reg_addr", 32'(reg_addr), 32'd0);
    check("dump valid end", 32'(bus.dump_valid), 32'd0);

    // reset in the middle of a dump
    do_reset();
    send_cmd(OP_DUMP, 32'd0);
    bus.dump_ready = 1'b1;
    guard = 0;
    while (!(bus.dump_valid && bus.dump_addr == 5'd7) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.dump_ready = 1'b0;
    check("mid reach addr 7", 32'(guard < 200), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid dump_valid", 32'(bus.dump_valid), 32'd0);
    check("mid halted", 32'(halted), 32'd1);
    check("mid reg_addr", 32'(reg_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    any_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.dump_valid) any_en = 1'b1;
      @(posedge clk); #1;
    end
    check("mid no dump_valid", 32'(any_en), 32'd0);
    check("mid halted after", 32'(halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_run_ctrl.md
SM_RUN_CTRL -- requirements
Module: sm_run_ctrl

Interface
REQ-001 SHALL have parameter CYCLE_LIMIT, default 200, meaning enabled CPU cycles before auto-halt; 0 disables the limit.
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning width of pc and breakpoint address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command strobe.
REQ-006 SHALL have port cmd_op  input  3  opcode: 0 RUN, 1 HALT, 2 STEP, 3 DUMP, 4 SET_BP, 5 CLR_BP, 6-7 illegal.
REQ-007 SHALL have port cmd_arg  input  PC_WIDTH  breakpoint address for SET_BP.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-009 SHALL have port cmd_err  output  1  one-cycle pulse on an accepted command that has no effect.
REQ-010 SHALL have port pc  input  PC_WIDTH  current CPU program counter.
REQ-011 SHALL have port cpu_en  output  1  CPU clock enable (drives clkEnable).
REQ-012 SHALL have port reg_addr  output  5  register-file debug read address (drives regAddr).
REQ-013 SHALL have port reg_data  input  32  asynchronous register-file read data (from regData).
REQ-014 SHALL have port dump_valid / dump_ready / dump_addr[4:0] / dump_data[31:0]  out/in/out/out  register dump stream.
REQ-015 SHALL have port halted  output  1  high in HALTED state.
REQ-016 SHALL have port bp_hit, limit_hit  output  1 each  one-cycle pulses on halt cause.
REQ-017 SHALL have port cycle_cnt  output  32  count of cycles with cpu_en=1.

Function
REQ-018 SHALL implement states HALTED, RUN, STEP, DUMP_ADDR, DUMP_OUT.
REQ-019 cmd_ready SHALL be 1 in HALTED and RUN, 0 otherwise.
REQ-020 HALTED: RUN -> RUN; STEP -> STEP; DUMP -> DUMP_ADDR with reg_addr=0; HALT -> stays, cmd_err pulse.
REQ-021 RUN: HALT -> HALTED next cycle; RUN/STEP/DUMP -> ignored, cmd_err pulse.
REQ-022 SET_BP (any ready state) SHALL load bp_addr=cmd_arg, bp_valid=1; CLR_BP SHALL clear bp_valid; illegal opcodes SHALL pulse cmd_err.
REQ-023 cpu_en SHALL be combinational: 1 in STEP; 1 in RUN unless breakpoint match or HALT accepted this cycle; 0 otherwise.
REQ-024 Breakpoint match = bp_valid & (pc==bp_addr) while in RUN; SHALL force cpu_en=0, go HALTED, pulse bp_hit; instruction at bp_addr not executed.
REQ-025 STEP SHALL assert cpu_en exactly one cycle, ignore breakpoint, then return to HALTED.
REQ-026 cycle_cnt SHALL increment on every edge where cpu_en=1, wrapping 2^32-1 -> 0.
REQ-027 If CYCLE_LIMIT!=0 and an enabled cycle makes cycle_cnt==CYCLE_LIMIT, state SHALL go HALTED and limit_hit pulse; further RUN/STEP still accepted.
REQ-028 Breakpoint match and limit in same cycle: breakpoint wins, limit_hit not pulsed.
REQ-029 DUMP_ADDR SHALL hold reg_addr one cycle, then DUMP_OUT registers dump_data=reg_data, dump_addr=reg_addr, dump_valid=1.
REQ-030 dump_valid/data/addr SHALL hold stable until dump_ready; on handshake reg_addr increments, -> DUMP_ADDR; handshake at addr 31 -> HALTED, reg_addr=0.
REQ-031 cpu_en SHALL be 0 throughout DUMP states.

Reset
REQ-032 rst SHALL asynchronously force HALTED, cpu_en=0, cycle_cnt=0, bp_valid=0, bp_addr=0, reg_addr=0, dump_valid=0, all pulses 0, halted=1.
REQ-033 rst mid-RUN or mid-DUMP SHALL abandon the operation; no dump_valid after release.

Configuration
REQ-034 Macro SM_RUN_CTRL_BP_EN defined: breakpoint logic per REQ-022/024/028.
REQ-035 Macro undefined: no bp registers; SET_BP/CLR_BP accepted with cmd_err pulse; bp_hit tied 0.

Verification
REQ-036 Reset, RUN, CYCLE_LIMIT=200 -> cpu_en high 200 cycles, cycle_cnt=200, limit_hit one pulse, halted=1.
REQ-037 SET_BP 0x0000_0010, RUN, pc steps by 4 from 0 -> cpu_en low when pc=0x10, bp_hit pulse, cycle_cnt=4; STEP -> pc 0x14, cycle_cnt=5.
REQ-038 DUMP with dump_ready random 50% -> 32 transfers, dump_addr 0..31 in order, dump_data equals register file, then halted=1.
REQ-039 RUN then DUMP while running -> cmd_err pulse, state stays RUN; HALT -> cpu_en 0 same cycle.
REQ-040 rst asserted during DUMP at addr 7 -> dump_valid 0 immediately, halted=1, reg_addr=0.
REQ-041 Macro undefined: SET_BP 0x10, RUN -> cmd_err pulse, no halt at 0x10, bp_hit never 1.
